// File: rtl/enc_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming SECDED encoder.
// Every function here is usable both as a constant function and in combinational logic.
package enc_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_8  = 2'd0;
  localparam mode_t MODE_16 = 2'd1;
  localparam mode_t MODE_32 = 2'd2;
  localparam mode_t MODE_64 = 2'd3;

  localparam int MIN_CODEWORD_WIDTH = 8;
  localparam int MAX_SUPPORTED_WIDTH = 64;

  function automatic int mode_width(input mode_t m);
    return 8 << m;
  endfunction

  // Check bits of an N-bit extended code: log2(N) Hamming parities plus the overall parity.
  function automatic int parity_count(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int info_width(input int n);
    return n - parity_count(n);
  endfunction

  function automatic logic mode_legal(input mode_t m, input int max_width);
    return mode_width(m) <= max_width;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bit carried by non-power-of-two position p: p minus the parity slots below it, minus 1.
  function automatic int data_index(input int p);
    return p - $clog2(p) - 1;
  endfunction

  // Positions whose index has bit i set; parity p_i covers exactly these.
  function automatic logic [MAX_SUPPORTED_WIDTH-1:0] cover_mask(input int i);
    logic [MAX_SUPPORTED_WIDTH-1:0] m;
    m = '0;
    for (int p = 1; p < MAX_SUPPORTED_WIDTH; p++) begin
      if (((p >> i) & 1) == 1) m[p] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/enc_hamming_parity.sv
// Combinational Hamming placement: scatters info bits into non-power-of-two positions,
// truncates to the mode's width and fills parity positions 2^i. Bit 0 is left at zero.
module enc_hamming_parity
  import enc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  localparam int INFO_W = info_width(MAX_CODEWORD_WIDTH)
) (
  input  logic [INFO_W-1:0]             data,
  input  mode_t                         mode,
  output logic [MAX_CODEWORD_WIDTH-1:0] code
);

  localparam int W     = MAX_CODEWORD_WIDTH;
  localparam int LOG_W = $clog2(W);

  int             n;
  logic [W-1:0]   spread;
  logic [W-1:0]   mask;
  logic [W-1:0]   masked;
  logic [LOG_W-1:0] parity;

  assign n         = mode_width(mode);
  assign spread[0] = 1'b0;
  assign mask[0]   = 1'b0;

  // The data-to-position map does not depend on the mode; narrower modes just cut it off.
  for (genvar p = 1; p < W; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par_slot
      assign spread[p] = 1'b0;
    end else begin : g_data_slot
      assign spread[p] = data[data_index(p)];
    end
    assign mask[p] = (p < n);
  end

  assign masked = spread & mask;

  for (genvar i = 0; i < LOG_W; i++) begin : g_parity
    localparam logic [MAX_SUPPORTED_WIDTH-1:0] COVER = cover_mask(i);
    assign parity[i] = ^(masked & COVER[W-1:0]);
  end

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    code = masked;
    for (int i = 0; i < LOG_W; i++) begin
      code[1 << i] = parity[i];
    end
    if (!mode_legal(mode, W)) code = '0;
  end

endmodule

// File: rtl/enc_pipe.sv
// Two-stage SECDED encoder pipeline with valid/ready flow control: stage 1 holds the
// Hamming positions, stage 2 adds the overall parity bit and drives the outputs.
module enc_pipe
  import enc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    out_mod,
  output logic                          err_out
);

  localparam int W = MAX_CODEWORD_WIDTH;

  if (!is_pow2(W) || W < MIN_CODEWORD_WIDTH || W > MAX_SUPPORTED_WIDTH) begin : g_bad_width
    $error("enc_pipe: MAX_CODEWORD_WIDTH must be a power of two in 8..64");
  end
  if (MAX_INFO_WIDTH != info_width(W)) begin : g_bad_info
    $error("enc_pipe: MAX_INFO_WIDTH must equal MAX_CODEWORD_WIDTH - log2(MAX_CODEWORD_WIDTH) - 1");
  end

  logic         s1_valid, s2_valid;
  logic         s1_load, s2_load;
  logic [W-1:0] code_next;
  logic [W-1:0] s1_code;
  mode_t        s1_mod;
  logic         s1_err;

  enc_hamming_parity #(.MAX_CODEWORD_WIDTH(W)) u_parity (
    .data (data_in),
    .mode (mode_t'(mod)),
    .code (code_next)
  );

  // in_ready follows out_ready combinationally so a full pipe can drain and refill in one edge.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = rst && (!s1_valid || s2_load);
  assign in_ready = s1_load;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the data registers are reset too because data_out must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_code <= '0;
      s1_mod  <= MODE_8;
      s1_err  <= 1'b0;
    end else if (s1_load && in_valid) begin
      s1_code <= code_next;
      s1_mod  <= mode_t'(mod);
      s1_err  <= !mode_legal(mode_t'(mod), W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      data_out <= '0;
      out_mod  <= MODE_8;
      err_out  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= {s1_code[W-1:1], ^s1_code[W-1:1]};
        out_mod  <= s1_mod;
        err_out  <= s1_err;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_enc_pipe.sv
// Randomised and directed bench for enc_pipe at 32-bit and 64-bit widths, checked
// against a positional Hamming reference model and a timing-aware scoreboard.
module tb_enc_pipe;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mod;
    logic        err;
    int          tick;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        iv0, ir0, ov0, or0, eo0;
  logic [25:0] di0;
  logic [1:0]  m0, om0;
  logic [31:0] do0;

  logic        iv1, ir1, ov1, or1, eo1;
  logic [56:0] di1;
  logic [1:0]  m1, om1;
  logic [63:0] do1;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb [2][$];
  logic acc [2];

  enc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .data_in(di0), .mod(m0),
    .out_valid(ov0), .out_ready(or0), .data_out(do0), .out_mod(om0), .err_out(eo0)
  );

  enc_pipe #(.MAX_CODEWORD_WIDTH(64), .MAX_INFO_WIDTH(57)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .data_in(di1), .mod(m1),
    .out_valid(ov1), .out_ready(or1), .data_out(do1), .out_mod(om1), .err_out(eo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook construction: place data in ascending non-power-of-two slots, then fill parities.
  function automatic logic [63:0] ref_enc(input int maxw, input logic [1:0] m, input logic [63:0] d);
    int          n;
    int          di;
    logic        p;
    logic [63:0] c;
    n  = 8 << m;
    di = 0;
    c  = '0;
    if (n > maxw) return '0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[di];
        di++;
      end
    end
    for (int pp = 1; pp < n; pp = pp * 2) begin
      p = 1'b0;
      for (int pos = 1; pos < n; pos++) if ((pos & pp) != 0) p = p ^ c[pos];
      c[pp] = p;
    end
    c[0] = ^c;
    return c;
  endfunction

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] want);
    errors++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic sample_port(input int id, input logic iv, input logic ir, input logic ov,
                             input logic orr, input logic [63:0] din, input logic [1:0] m,
                             input logic [63:0] dout, input logic [1:0] om, input logic eo);
    logic exp_ir, exp_ov;
    int   maxw;
    exp_t e;
    maxw   = (id == 0) ? 32 : 64;
    exp_ir = orr || (sb[id].size() < 2);
    exp_ov = (sb[id].size() > 0) && ((cyc - sb[id][0].tick) >= 2);
    checks++;
    if (ir !== exp_ir) fail($sformatf("in_ready[%0d]", id), 64'(ir), 64'(exp_ir));
    checks++;
    if (ov !== exp_ov) fail($sformatf("out_valid[%0d]", id), 64'(ov), 64'(exp_ov));
    if (ov === 1'b1 && sb[id].size() > 0) begin
      e = sb[id][0];
      checks++;
      if (dout !== e.data) fail($sformatf("data_out[%0d]", id), dout, e.data);
      checks++;
      if (om !== e.mod) fail($sformatf("out_mod[%0d]", id), 64'(om), 64'(e.mod));
      checks++;
      if (eo !== e.err) fail($sformatf("err_out[%0d]", id), 64'(eo), 64'(e.err));
      if (orr) void'(sb[id].pop_front());
    end
    acc[id] = iv && ir;
    if (acc[id]) begin
      e.data = ref_enc(maxw, m, din);
      e.mod  = m;
      e.err  = (8 << m) > maxw;
      e.tick = cyc;
      sb[id].push_back(e);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1;
    if (rst) begin
      sample_port(0, iv0, ir0, ov0, or0, {38'b0, di0}, m0, {32'b0, do0}, om0, eo0);
      sample_port(1, iv1, ir1, ov1, or1, {7'b0, di1}, m1, do1, om1, eo1);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    for (int i = 0; i < 8 && (sb[0].size() + sb[1].size()) > 0; i++) tick();
    checks++;
    if (sb[0].size() + sb[1].size() != 0) fail("drain_timeout", 64'(sb[0].size() + sb[1].size()), 64'd0);
  endtask

  task automatic send_one(input int id, input logic [1:0] m, input logic [63:0] d,
                          input logic [63:0] exp_data, input logic exp_err);
    if (id == 0) begin iv0 = 1'b1; m0 = m; di0 = d[25:0]; or0 = 1'b1; end
    else         begin iv1 = 1'b1; m1 = m; di1 = d[56:0]; or1 = 1'b1; end
    tick();
    iv0 = 1'b0; iv1 = 1'b0;
    checks++;
    if (((id == 0) ? ov0 : ov1) !== 1'b0) fail("latency_early", 64'd1, 64'd0);
    tick();
    checks++;
    if (((id == 0) ? ov0 : ov1) !== 1'b1) fail("latency_two", 64'd0, 64'd1);
    checks++;
    if (((id == 0) ? {32'b0, do0} : do1) !== exp_data)
      fail($sformatf("vector m%0d", m), (id == 0) ? {32'b0, do0} : do1, exp_data);
    checks++;
    if (((id == 0) ? eo0 : eo1) !== exp_err) fail("vector_err", 64'((id == 0) ? eo0 : eo1), 64'(exp_err));
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iv0 = 1'b0; or0 = 1'b1; di0 = '0; m0 = '0;
    iv1 = 1'b0; or1 = 1'b1; di1 = '0; m1 = '0;
    #1;
    checks++; if (ov0 !== 1'b0) fail("reset_out_valid", 64'(ov0), 64'd0);
    checks++; if (ir0 !== 1'b0) fail("reset_in_ready", 64'(ir0), 64'd0);
    checks++; if (do0 !== 32'd0) fail("reset_data_out", 64'(do0), 64'd0);
    checks++; if ({om0, eo0} !== 3'd0) fail("reset_mod_err", 64'({om0, eo0}), 64'd0);
    checks++; if (ov1 !== 1'b0) fail("reset_out_valid64", 64'(ov1), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    send_one(0, 2'd0, 64'b1011, 64'h0000_00AA, 1'b0);
    send_one(0, 2'd1, 64'h7FF, 64'h0000_FFFF, 1'b0);
    send_one(0, 2'd2, 64'h3FF_FFFF, 64'hFFFF_FFFF, 1'b0);
    for (int m = 0; m < 3; m++) send_one(0, 2'(m), 64'd0, 64'd0, 1'b0);
    send_one(0, 2'd3, 64'h155_5555, 64'd0, 1'b1);
    send_one(0, 2'd0, 64'b1011, 64'h0000_00AA, 1'b0);
  endtask

  task automatic test_wide64();
    send_one(1, 2'd3, {7'b0, {57{1'b1}}}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_one(1, 2'd0, 64'b1011, 64'h0000_00AA, 1'b0);
    send_one(1, 2'd3, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int sent;
    sent = 0;
    or0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      iv0 = 1'b1; m0 = 2'($urandom_range(0, 3)); di0 = 26'($urandom);
      tick();
      if (acc[0]) sent++;
    end
    checks++;
    if (sent != 12) fail("back_to_back_accepts", 64'(sent), 64'd12);
    drain();
  endtask

  task automatic test_stall();
    int  sent;
    logic saw_block;
    sent = 0;
    saw_block = 1'b0;
    for (int t = 0; t < 40 && sent < 10; t++) begin
      or0 = !(t >= 3 && t <= 6);
      iv0 = 1'b1; m0 = 2'($urandom_range(0, 2)); di0 = 26'($urandom);
      if (!or0 && !ir0) saw_block = 1'b1;
      tick();
      if (acc[0]) sent++;
    end
    checks++;
    if (sent != 10) fail("stall_accepts", 64'(sent), 64'd10);
    checks++;
    if (saw_block !== 1'b1) fail("stall_in_ready_low", 64'(saw_block), 64'd1);
    drain();
  endtask

  task automatic test_reset_midstream();
    or0 = 1'b0; or1 = 1'b0;
    iv0 = 1'b1; m0 = 2'd1; di0 = 26'($urandom);
    iv1 = 1'b1; m1 = 2'd3; di1 = {$urandom, $urandom};
    tick();
    tick();
    iv0 = 1'b0; iv1 = 1'b0;
    checks++;
    if (ov0 !== 1'b1) fail("midstream_full", 64'(ov0), 64'd1);
    #2 rst = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) fail("async_out_valid", 64'(ov0), 64'd0);
    checks++; if (ov1 !== 1'b0) fail("async_out_valid64", 64'(ov1), 64'd0);
    checks++; if (ir0 !== 1'b0) fail("async_in_ready", 64'(ir0), 64'd0);
    checks++; if ({do0, om0, eo0} !== 35'd0) fail("async_outputs", 64'({do0, om0, eo0}), 64'd0);
    sb[0].delete();
    sb[1].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; or0 = 1'b1; or1 = 1'b1;
    repeat (4) tick();
    send_one(0, 2'd0, 64'b1011, 64'h0000_00AA, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iv0 = ($urandom_range(0, 3) != 0); or0 = ($urandom_range(0, 3) != 0);
      m0 = 2'($urandom_range(0, 3)); di0 = 26'($urandom);
      iv1 = ($urandom_range(0, 3) != 0); or1 = ($urandom_range(0, 3) != 0);
      m1 = 2'($urandom_range(0, 3)); di1 = 57'({$urandom, $urandom});
      tick();
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    test_reset();
    test_vectors();
    test_wide64();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_pipe.md
ENC_PIPE -- requirements
Module: enc_pipe

Interface
REQ-001 Parameter MAX_CODEWORD_WIDTH, default 32: widest codeword; power of two, range 8..64.
REQ-002 Parameter MAX_INFO_WIDTH, default 26: equals MAX_CODEWORD_WIDTH - log2(MAX_CODEWORD_WIDTH) - 1; any other value is an elaboration error.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  data_in/mod valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 data_in  input  MAX_INFO_WIDTH  info word, LSB-aligned; bits above mode's k ignored.
REQ-008 mod  input  2  mode: codeword width N = 8<<mod.
REQ-009 out_valid  output  1  data_out/out_mod/err_out valid.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 data_out  output  MAX_CODEWORD_WIDTH  codeword, LSB-aligned, zero-padded above N.
REQ-012 out_mod  output  2  mode captured with the word.
REQ-013 err_out  output  1  word carried an illegal mode.

Function
REQ-014 Mode legal iff N <= MAX_CODEWORD_WIDTH; k = N - log2(N) - 1 (8->4, 16->11, 32->26, 64->57).
REQ-015 Code: extended Hamming SECDED; codeword positions 1..N-1 hold Hamming code, position 2^i holds parity bit p_i, other positions take data bits in ascending order from data_in[0].
REQ-016 p_i = XOR of all data positions whose index has bit i set.
REQ-017 Bit 0 = overall parity = XOR of bits 1..N-1 (even total weight).
REQ-018 Stage 1 registers positions 1..N-1 plus mode/err; stage 2 registers bit 0 and presents the word; latency exactly 2 cycles from accept to out_valid when unstalled.
REQ-019 Throughput one word per cycle with out_ready held high.
REQ-020 Transfer occurs when valid and ready both high on a rising edge; no other event moves data.
REQ-021 Stage 2 loads when empty or out_ready=1; stage 1 loads when empty or stage 2 loads; in_ready = stage 1 loads (combinational from out_ready, no extra bubble).
REQ-022 out_valid, once high, stays high and data_out/out_mod/err_out stay stable until out_ready=1.
REQ-023 Illegal mode: word accepted normally, data_out = 0, out_mod = mod, err_out = 1; pipeline not stalled.
REQ-024 Mode may change every accepted word; each word encoded with its own captured mode.
REQ-025 Simultaneous output drain and input accept with pipeline full: both occur, no loss, no duplication.
REQ-026 out_ready and out_valid have no combinational path to data_out.

Reset
REQ-027 rst low: both stage valid flags 0 immediately (asynchronous), out_valid=0, data_out=0, out_mod=0, err_out=0.
REQ-028 in_ready is 0 while rst low and 1 in the first cycle after release.
REQ-029 Reset mid-stream discards all in-flight words; none appear after release.

Structure
REQ-030 Package enc_pkg holds: mode typedef (2 bits), parity-count/info-width functions of N, legality check, mode localparams.
REQ-031 One sub-module enc_hamming_parity (combinational, parameterised by MAX_CODEWORD_WIDTH) produces positions 1..N-1 for a given mode; instantiated once in stage 1.
REQ-032 Overall-parity XOR and handshake logic live in enc_pipe.

Verification
REQ-033 Default params, mod=0, data_in=4'b1011, out_ready=1 -> 2 cycles later data_out=32'h000000AA, err_out=0.
REQ-034 mod=1, data_in=11'h7FF -> data_out=32'h0000FFFF; mod=2, data_in=26'h3FFFFFF -> data_out=32'hFFFFFFFF; data_in=0 any legal mode -> 0.
REQ-035 mod=3 (default params) -> data_out=0, out_mod=3, err_out=1; next word mod=0 data 4'b1011 -> 32'hAA.
REQ-036 Stream of 10 words, out_ready low cycles 3-6 -> in_ready low once both stages full, outputs stable while stalled, all 10 words out in order, none lost.
REQ-037 rst asserted while two words in flight -> out_valid 0 asynchronously, no output after release; first new word appears 2 cycles after accept.
REQ-038 MAX_CODEWORD_WIDTH=64, mod=3, data_in all ones (57 bits) -> data_out=64'hFFFFFFFFFFFFFFFF; random compare against reference model for all modes.
